// File: rtl/commit_trace_buffer.sv
// Retirement trace FIFO: first-word-fall-through, a push is visible at the head right after its edge; out_ready may stall indefinitely and a full FIFO drops and counts commits.
// The TRACE_FILTER_EN macro keeps only register/memory writers and the terminating commit.

// Generic FWFT FIFO. The caller must never push when full without a same-cycle pop, and never pop when empty.
module ctb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  assign head_dat = mem[rd_ptr];

  // Storage is reset so the head reads all-zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_vld) rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop_vld})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module commit_trace_buffer #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] PC_LIMIT = 32'h0000_0200,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_instr,
  input  logic             commit_rd_we,
  input  logic [4:0]       commit_rd,
  input  logic [31:0]      commit_rd_data,
  input  logic             commit_mem_we,
  input  logic [31:0]      commit_mem_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_rd_data,
  output logic [31:0]      out_mem_addr,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic             out_mem_we,
  output logic [31:0]      retired_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        mem_we;
    logic [31:0] mem_addr;
  } entry_t;

  typedef enum logic [1:0] {RUN, DRAIN, FINISHED} state_t;

  state_t      state;
  entry_t      in_dat;
  entry_t      head;
  logic [AW:0] count;
  logic [AW:0] cnt_after_pop;
  logic        pop;
  logic        eligible;
  logic        instr_x;
  logic        term;
  logic        keep;
  logic        room;
  logic        push;
  logic        drop;

  assign out_valid     = (count != '0);
  assign pop           = out_valid && out_ready;
  assign cnt_after_pop = count - (AW+1)'(pop);
  assign eligible      = commit_valid && (state == RUN);

  // Evaluates false in synthesis and in 2-state simulation.
  assign instr_x = ((^commit_instr) === 1'bx);
  assign term    = (commit_instr == 32'h0000_0063) || (commit_instr == 32'h0000_0000) ||
                   instr_x || (commit_pc >= PC_LIMIT);

`ifdef TRACE_FILTER_EN
  assign keep = (commit_rd_we && (commit_rd != 5'd0)) || commit_mem_we || term;
`else
  assign keep = 1'b1;
`endif

  // A full FIFO still has room when the head leaves on the same edge.
  assign room = (count < DEPTH_C) || pop;
  assign push = eligible && keep && room;
  assign drop = eligible && keep && !room;

  always_comb begin
    in_dat          = '0;
    in_dat.pc       = commit_pc;
    in_dat.instr    = commit_instr;
    in_dat.rd_we    = commit_rd_we && (commit_rd != 5'd0);
    in_dat.rd       = commit_rd;
    in_dat.rd_data  = commit_rd_data;
    in_dat.mem_we   = commit_mem_we;
    in_dat.mem_addr = commit_mem_addr;
  end

  ctb_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push),
    .push_dat (in_dat),
    .pop_vld  (pop),
    .head_dat (head),
    .count    (count)
  );

  assign out_pc       = head.pc;
  assign out_instr    = head.instr;
  assign out_rd_we    = head.rd_we;
  assign out_rd       = head.rd;
  assign out_rd_data  = head.rd_data;
  assign out_mem_we   = head.mem_we;
  assign out_mem_addr = head.mem_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RUN;
      done          <= 1'b0;
      retired_count <= '0;
      drop_count    <= '0;
    end else begin
      if (eligible) retired_count <= retired_count + 32'd1;
      if (drop && (drop_count != {CNT_W{1'b1}})) drop_count <= drop_count + 1'b1;
      case (state)
        RUN: begin
          if (eligible && term) state <= DRAIN;
        end
        DRAIN: begin
          if (cnt_after_pop == '0) begin
            state <= FINISHED;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: vector table, directed corner sequences, random run against a queue model.
module tb_commit_trace_buffer;
  localparam int DEPTH = 16;
`ifdef TRACE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] commit_instr = '0;
  logic        commit_rd_we = 1'b0;
  logic [4:0]  commit_rd = '0;
  logic [31:0] commit_rd_data = '0;
  logic        commit_mem_we = 1'b0;
  logic [31:0] commit_mem_addr = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc, out_instr, out_rd_data, out_mem_addr;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_mem_we;
  logic [31:0] retired_count;
  logic [15:0] drop_count;
  logic        done;

  commit_trace_buffer #(.DEPTH(DEPTH), .PC_LIMIT(32'h200), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_rd_we(commit_rd_we), .commit_rd(commit_rd), .commit_rd_data(commit_rd_data),
    .commit_mem_we(commit_mem_we), .commit_mem_addr(commit_mem_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_rd_data(out_rd_data), .out_mem_addr(out_mem_addr),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_mem_we(out_mem_we),
    .retired_count(retired_count), .drop_count(drop_count), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of trace records plus the three-phase program status.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        mem_we;
    logic [31:0] mem_addr;
  } ent_t;

  ent_t        mq[$];
  int          mstate;        // 0 running, 1 draining, 2 finished
  int unsigned m_retired;
  int unsigned m_drops;

  task automatic model_reset();
    mq.delete();
    mstate    = 0;
    m_retired = 0;
    m_drops   = 0;
  endtask

  task automatic model_step();
    bit   popm, termm, keepm;
    int   old;
    ent_t e;
    if (!rst) begin
      model_reset();
      return;
    end
    old  = mstate;
    popm = (mq.size() != 0) && out_ready;
    if (popm) mq.delete(0);
    if (old == 0 && commit_valid) begin
      m_retired++;
      termm = (commit_instr == 32'h63) || (commit_instr == 32'h0) || (commit_pc >= 32'h200);
      keepm = FILT ? ((commit_rd_we && commit_rd != 0) || commit_mem_we || termm) : 1'b1;
      if (keepm) begin
        if (mq.size() < DEPTH) begin
          e.pc = commit_pc; e.instr = commit_instr;
          e.rd_we = commit_rd_we && (commit_rd != 0); e.rd = commit_rd;
          e.rd_data = commit_rd_data; e.mem_we = commit_mem_we; e.mem_addr = commit_mem_addr;
          mq.push_back(e);
        end else if (m_drops < 65535) begin
          m_drops++;
        end
      end
      if (termm) mstate = 1;
    end else if (old == 1 && mq.size() == 0) begin
      mstate = 2;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk({tag, ".pc"},       out_pc,              mq[0].pc);
      chk({tag, ".instr"},    out_instr,           mq[0].instr);
      chk({tag, ".rd_we"},    32'(out_rd_we),      32'(mq[0].rd_we));
      chk({tag, ".rd"},       32'(out_rd),         32'(mq[0].rd));
      chk({tag, ".rd_data"},  out_rd_data,         mq[0].rd_data);
      chk({tag, ".mem_we"},   32'(out_mem_we),     32'(mq[0].mem_we));
      chk({tag, ".mem_addr"}, out_mem_addr,        mq[0].mem_addr);
    end
    chk({tag, ".retired"}, retired_count,    m_retired);
    chk({tag, ".drops"},   32'(drop_count),  m_drops);
    chk({tag, ".done"},    32'(done),        32'(mstate == 2));
  endtask

  task automatic set_in(input bit cv, input logic [31:0] pc, input logic [31:0] instr,
                        input bit rdwe, input logic [4:0] rd, input logic [31:0] rdd,
                        input bit mwe, input logic [31:0] ma, input bit rdy);
    commit_valid = cv; commit_pc = pc; commit_instr = instr; commit_rd_we = rdwe;
    commit_rd = rd; commit_rd_data = rdd; commit_mem_we = mwe; commit_mem_addr = ma;
    out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Asynchronous reset applied away from any edge; outputs must clear at once.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    model_reset();
    #1;
    chk({tag, ".rst_valid"},   32'(out_valid),  32'd0);
    chk({tag, ".rst_done"},    32'(done),       32'd0);
    chk({tag, ".rst_retired"}, retired_count,   32'd0);
    chk({tag, ".rst_drops"},   32'(drop_count), 32'd0);
    rst = 1'b1;
  endtask

  typedef struct {
    bit          cv;
    logic [31:0] pc, instr;
    bit          rdwe;
    logic [4:0]  rd;
    logic [31:0] rdd;
    bit          mwe;
    logic [31:0] ma;
    bit          rdy;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_rdwe, e_mwe;
    logic [31:0] e_ma, e_ret;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] cur_pc;
    int          rdy_pct;
    int          r;

    vecs[0] = '{1, 32'h0, 32'h00500093, 1, 5'd1, 32'd5, 0, 32'h5, 1,   1, 32'h0, 1, 0, 32'h5, 32'd1};
    vecs[1] = '{1, 32'h4, 32'h00700113, 1, 5'd2, 32'd7, 0, 32'h7, 1,   1, 32'h4, 1, 0, 32'h7, 32'd2};
    vecs[2] = '{1, 32'h8, 32'h0020a023, 0, 5'd0, 32'd0, 1, 32'h5, 1,   1, 32'h8, 0, 1, 32'h5, 32'd3};
    vecs[3] = '{0, 32'h0, 32'h0,        0, 5'd0, 32'd0, 0, 32'h0, 1,   0, 32'h0, 0, 0, 32'h0, 32'd3};
    vecs[4] = '{1, 32'hC, 32'h00100013, 1, 5'd0, 32'd1, 0, 32'h1, 0, !FILT, 32'hC, 0, 0, 32'h1, 32'd4};
    vecs[5] = '{0, 32'h0, 32'h0,        0, 5'd0, 32'd0, 0, 32'h0, 1,   0, 32'h0, 0, 0, 32'h0, 32'd4};

    // Reset held across two edges with commits toggling.
    model_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(i == 0, 32'h0, 32'h13, 1, 5'd1, 32'd1, 0, 32'h0, 1);
      tick();
      chk("hold.valid",   32'(out_valid),  32'd0);
      chk("hold.retired", retired_count,   32'd0);
      chk("hold.drops",   32'(drop_count), 32'd0);
      chk("hold.done",    32'(done),       32'd0);
      chk("hold.pc",      out_pc,          32'd0);
      chk("hold.mem_we",  32'(out_mem_we), 32'd0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // Basic flow vectors.
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].cv, vecs[i].pc, vecs[i].instr, vecs[i].rdwe, vecs[i].rd, vecs[i].rdd,
             vecs[i].mwe, vecs[i].ma, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d.valid", i),   32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.retired", i), retired_count,  vecs[i].e_ret);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d.pc", i),       out_pc,          vecs[i].e_pc);
        chk($sformatf("vec%0d.rd_we", i),    32'(out_rd_we),  32'(vecs[i].e_rdwe));
        chk($sformatf("vec%0d.mem_we", i),   32'(out_mem_we), 32'(vecs[i].e_mwe));
        chk($sformatf("vec%0d.mem_addr", i), out_mem_addr,    vecs[i].e_ma);
      end
    end

    // Overflow: 20 commits into a stalled 16-deep FIFO, then a push while full and popping.
    do_reset("ovf");
    for (int i = 0; i < 20; i++) begin
      set_in(1, 32'(i * 4), 32'h00300193, 1, 5'd3, 32'(i), 0, 32'h0, 0);
      tick();
    end
    chk("ovf.valid",   32'(out_valid),  32'd1);
    chk("ovf.head",    out_pc,          32'h0);
    chk("ovf.drops",   32'(drop_count), 32'd4);
    chk("ovf.retired", retired_count,   32'd20);
    set_in(1, 32'h50, 32'h00300193, 1, 5'd3, 32'd99, 0, 32'h0, 1);
    tick();
    chk("fullpop.drops",   32'(drop_count), 32'd4);
    chk("fullpop.retired", retired_count,   32'd21);
    chk("fullpop.head",    out_pc,          32'h4);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("drain%0d.pc", j), out_pc, (j < 15) ? 32'((j + 1) * 4) : 32'h50);
      tick();
    end
    chk("drain.empty", 32'(out_valid), 32'd0);

    // Termination with two entries queued; commits during drain are ignored.
    do_reset("term");
    set_in(1, 32'h18, 32'h00300193, 1, 5'd3, 32'd1, 0, 32'h0, 0); tick();
    set_in(1, 32'h1C, 32'h00300193, 1, 5'd3, 32'd2, 0, 32'h0, 0); tick();
    set_in(1, 32'h20, 32'h00000063, 0, 5'd0, 32'd0, 0, 32'h0, 1); tick();
    chk("term.e1.pc",   out_pc,        32'h1C);
    chk("term.e1.done", 32'(done),     32'd0);
    chk("term.e1.ret",  retired_count, 32'd3);
    set_in(1, 32'h24, 32'h00500093, 1, 5'd1, 32'd5, 0, 32'h5, 1); tick();
    chk("term.e2.pc",    out_pc,        32'h20);
    chk("term.e2.instr", out_instr,     32'h63);
    chk("term.e2.done",  32'(done),     32'd0);
    chk("term.e2.ret",   retired_count, 32'd3);
    tick();
    chk("term.fin.valid", 32'(out_valid), 32'd0);
    chk("term.fin.done",  32'(done),      32'd1);
    tick();
    chk("term.after.done", 32'(done),     32'd1);
    chk("term.after.ret",  retired_count, 32'd3);

    // PC limit boundary: 0x1FC runs on, 0x200 terminates.
    do_reset("pcl");
    set_in(1, 32'h1FC, 32'h00300193, 1, 5'd3, 32'd1, 0, 32'h0, 1); tick();
    chk("pcl.1fc.pc",   out_pc,    32'h1FC);
    set_in(1, 32'h200, 32'h00300193, 1, 5'd3, 32'd2, 0, 32'h0, 1); tick();
    chk("pcl.200.pc",   out_pc,    32'h200);
    chk("pcl.200.done", 32'(done), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("pcl.fin.valid", 32'(out_valid), 32'd0);
    chk("pcl.fin.done",  32'(done),      32'd1);

    // Reset while draining returns to a running, empty buffer.
    do_reset("mid");
    set_in(1, 32'h0, 32'h00000063, 0, 5'd0, 32'd0, 0, 32'h0, 0); tick();
    chk("mid.valid", 32'(out_valid), 32'd1);
    do_reset("mid2");
    set_in(1, 32'h4, 32'h00300193, 1, 5'd3, 32'd7, 0, 32'h0, 0); tick();
    chk("mid.run.valid", 32'(out_valid), 32'd1);
    chk("mid.run.pc",    out_pc,         32'h4);
    chk("mid.run.ret",   retired_count,  32'd1);

`ifdef TRACE_FILTER_EN
    do_reset("filt");
    set_in(1, 32'h10, 32'h00208463, 0, 5'd8, 32'd0, 0, 32'h8, 1); tick();
    chk("filt.valid", 32'(out_valid), 32'd0);
    chk("filt.ret",   retired_count,  32'd1);
`endif

    // Random traffic against the model.
    do_reset("rnd");
    cur_pc  = 0;
    rdy_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) rdy_pct = $urandom_range(5, 95);
      if ($urandom_range(0, 299) == 0 || (mstate == 2 && $urandom_range(0, 7) == 0)) begin
        do_reset("rnd");
        cur_pc = 0;
      end
      r = $urandom_range(0, 99);
      set_in($urandom_range(0, 3) != 0, cur_pc & 32'h1FC, $urandom, 1'($urandom), 5'($urandom),
             $urandom, 1'($urandom), $urandom, $urandom_range(0, 99) < rdy_pct);
      if (r == 0) commit_instr = 32'h63;
      else if (r == 1) commit_instr = 32'h0;
      else if (r == 2) commit_pc = 32'h200 + $urandom_range(0, 1023);
      cur_pc = cur_pc + 4;
      tick();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the single-cycle RISC-V core and consumes its per-cycle retirement information: PC, instruction, register write-back and store.
- Buffers the retirements in a FIFO and presents them on a valid/ready trace stream, which a logger or UART bridge can drain at its own rate.
- Detects program termination from the retired instruction stream, drains the FIFO, then raises done.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- PC_LIMIT, 32'h00000200, a retired PC >= this value terminates the program.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  input  1  core clock
- rst  input  1  reset; asynchronous, active-low (0 = reset)
- commit_valid  input  1  the core retired one instruction this cycle
- commit_pc  input  32  PC of the retired instruction
- commit_instr  input  32  instruction word
- commit_rd_we  input  1  RegWrite
- commit_rd  input  5  destination register (instr[11:7])
- commit_rd_data  input  32  write-back Result
- commit_mem_we  input  1  MemWrite
- commit_mem_addr  input  32  ALUResult (store address)
- out_valid  output  1  head entry is available
- out_ready  input  1  consumer accepts the head entry
- out_pc, out_instr, out_rd_data, out_mem_addr  output  32 each  head entry fields
- out_rd  output  5  head entry destination register
- out_rd_we, out_mem_we  output  1 each  head entry flags
- retired_count  output  32  commits accepted in RUN state
- drop_count  output  CNT_W  commits lost because the FIFO was full
- done  output  1  terminated and FIFO empty

Behaviour:
- Reset (rst=0, async): rd/wr pointers 0, count 0, state RUN, out_valid 0, all out_* fields 0, retired_count 0, drop_count 0, done 0.
- FIFO is first-word-fall-through. out_valid = (count != 0). The out_* fields show the head entry combinationally from the storage array.
- Pop: out_valid && out_ready at a clk rising edge.
- An entry is recorded as {pc, instr, rd_we & (rd != 0), rd, rd_data, mem_we, mem_addr}. A write to x0 is stored with out_rd_we=0.
- Eligible commit: commit_valid=1 and state=RUN.
- Push: an eligible commit is pushed when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle. Count is then unchanged.
- Drop: an eligible commit with no room increments drop_count, which saturates at all-ones. The FIFO is unchanged.
- retired_count increments on every eligible commit, pushed or dropped, and wraps modulo 2^32.
- Simultaneous push and pop with count=0 is impossible, because out_valid=0 at that point. The push is performed and count becomes 1.
- Termination: an eligible commit terminates the program when any of these holds:
  - commit_instr == 32'h00000063 (BEQ x0,x0,0)
  - commit_instr == 32'h00000000
  - commit_instr has any X/Z bit; simulation-only check, synthesizes to false
  - commit_pc >= PC_LIMIT (unsigned compare)
- The terminating commit is itself pushed, or dropped, and counted like any other.
- States:
  - RUN: on a terminating commit -> DRAIN.
  - DRAIN: commits ignored, not counted, not dropped. When count == 0 after the edge's pop -> DONE.
  - DONE: done=1. Commits ignored. Stays in DONE until reset.
- Terminating commit with an empty FIFO: RUN -> DRAIN in that cycle (the entry is pushed), then DRAIN -> DONE one cycle after the last pop.
- out_ready held low forever: the block stays in DRAIN indefinitely. This is legal.
- Reset mid-DRAIN returns to RUN with an empty FIFO; buffered entries are lost.

Optional Feature:
- Macro: TRACE_FILTER_EN.
- Defined: only commits with (commit_rd_we && commit_rd != 0) || commit_mem_we, or terminating commits, are pushed or dropped. retired_count still counts every eligible commit.
- Undefined: every eligible commit is pushed.

Test Plan:
- Reset hold: hold rst=0 for 2 cycles with commit_valid toggling -> out_valid=0, retired_count=0, drop_count=0, done=0.
- Basic flow: 3 commits ADDI x1,x0,5 @0x0, ADDI x2,x0,7 @0x4, SW x2,0(x1) @0x8 with out_ready=1 -> 3 in-order entries; the third has out_mem_we=1, out_mem_addr=0x5, out_rd_we=0. retired_count=3.
- Overflow: out_ready=0, DEPTH=16, 20 commits -> count=16, drop_count=4, retired_count=20. Then raise out_ready for 16 cycles -> the first 16 PCs appear in order.
- Full with pop: count=16 and out_ready=1 while a commit arrives -> the commit is pushed, count stays 16, drop_count unchanged.
- Termination: commit 0x00000063 @0x20 with 2 entries queued and out_ready=1 -> state DRAIN, 3 entries delivered, done=1 the cycle after the last pop. Later commits leave retired_count unchanged.
- PC limit: commit @0x200 -> treated as terminating. With TRACE_FILTER_EN, a BEQ @0x10 is not pushed but retired_count still increments.
